bin2bcd_seg_feeder: RTL and testbench
=====================================

Name: bin2bcd_seg_feeder

Overview:
- Bus-master stage directly upstream of the four-digit seven-segment display peripheral.
- Accepts a 14-bit binary value through a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble, one bit per cycle.
- Builds the display control byte: per-digit blank bits for leading-zero suppression, plus the decimal-point bit.
- Writes Control, SegmentPairA and SegmentPairB into the display over its 2-bit-address, 8-bit-data write bus.

Parameters:
- WRITE_DIV, 1, when 1 the block writes DIV_INIT to display address 1 (Divisor) once after reset.
- DIV_INIT, 8'h01, Divisor value written when WRITE_DIV=1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_value  in  14  binary value to display, 0..16383.
- in_dp_en  in  1  enables the decimal point.
- in_dp_pos  in  2  decimal-point digit: 0=D (rightmost), 1=C, 2=B, 3=A (leftmost).
- in_lz_en  in  1  enables leading-zero blanking.
- in_valid  in  1  request qualifier.
- in_ready  out  1  high only in IDLE.
- bus_addr  out  2  display register address.
- bus_data  out  8  display write data.
- bus_wr  out  1  one-cycle write strobe.
- bus_cen  out  1  chip enable; equals bus_wr.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final write.
- ovf  out  1  registered; set when the last accepted value was >9999.

Behaviour:
- Reset values (async): state=INIT if WRITE_DIV else IDLE; bus_addr=0, bus_data=0, bus_wr=0, bus_cen=0, done=0, ovf=0, in_ready=0; shift register cleared.
- Reset mid-operation aborts the sequence immediately; no partial write completes.
- States: INIT, IDLE, CONV, WR_CTRL, WR_A, WR_B, DONE.
- INIT: one cycle; bus_addr=1, bus_data=DIV_INIT, bus_wr=1. Next state IDLE.
- IDLE: in_ready=1. On in_valid:
  - Capture value, dp_en, dp_pos and lz_en.
  - Load a 30-bit register {16'h0, in_value}.
  - Bit counter = 0; ovf <= (in_value > 9999). Go to CONV.
- CONV: 14 cycles. Each cycle, every BCD nibble >=5 gets +3, then the whole 30-bit register shifts left by 1. Exit to WR_CTRL when the counter reaches 13.
- Overflow: if ovf, the digits are forced to E,E,E,E at CONV exit, with no blanking and the DP still applied. Latency is unchanged.
- Digit map: A = bcd[15:12], B = [11:8], C = [7:4], D = [3:0].
- Blanking, only when lz_en=1 and not ovf:
  - blankA = A==0.
  - blankB = blankA & B==0.
  - blankC = blankB & C==0.
  - D is never blanked.
- Control byte: {blankA,dpA, blankB,dpB, blankC,dpC, 1'b0,dpD}. dpX = dp_en & (dp_pos selects X).
- WR_CTRL: addr 0, data = control byte, bus_wr=1.
- WR_A: addr 2, data {A,B}, bus_wr=1.
- WR_B: addr 3, data {C,D}, bus_wr=1.
- Each write lasts exactly one cycle. Address and data are stable for the whole cycle; the display samples on negedge.
- DONE: done=1 for one cycle, then IDLE.
- Latency: accept at cycle N; writes at N+15, N+16, N+17; done at N+18; in_ready high again at N+19.
- Inputs are ignored while busy. in_valid held high restarts on the first IDLE cycle (back-to-back throughput is one value per 19 cycles).
- Bus outputs are all registered; bus_wr=0 outside the write states (bus_addr/bus_data hold their last value).

Decomposition:
- Shared package holds:
  - State encoding.
  - Display register addresses: ADDR_CTRL=0, ADDR_DIV=1, ADDR_PAIRA=2, ADDR_PAIRB=3.
  - Control-byte bit positions.
  - BCD_MAX=9999 and the overflow digit 4'hE.
- One sub-module: bcd_dabble_step (combinational add-3 on four nibbles plus shift of the 30-bit word), instantiated once in the FSM.

Test Plan:
- Reset, WRITE_DIV=1, DIV_INIT=8'h20 -> first cycle after reset release: addr=1, data=8'h20, bus_wr=1; then in_ready=1.
- value=1234, lz_en=1, dp_en=0 -> writes (0,8'h00), (2,8'h12), (3,8'h34) at N+15..17; done at N+18; ovf=0.
- value=42, lz_en=1 -> (0,8'hA0), (2,8'h00), (3,8'h42). value=0, lz_en=1 -> (0,8'hA8), (2,8'h00), (3,8'h00).
- value=10000 with dp_en=1, dp_pos=1 -> ovf=1; writes (0,8'h04), (2,8'hEE), (3,8'hEE).
- value=9999, lz_en=0, dp_en=1, dp_pos=3 -> (0,8'h40), (2,8'h99), (3,8'h99). Then in_valid held high across done -> second transfer accepted at N+19.
- Assert rst at CONV cycle 7 -> bus_wr stays 0, no done; after release, INIT write, then a fresh value=5 completes normally.

Source files
------------

// File: rtl/bin2bcd_seg_feeder_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment feeder: FSM states,
// display register map, control-byte layout and the control-byte builder.
package bin2bcd_seg_feeder_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CONV,
    ST_WR_CTRL,
    ST_WR_A,
    ST_WR_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DIV   = 2'd1;
  localparam logic [1:0] ADDR_PAIRA = 2'd2;
  localparam logic [1:0] ADDR_PAIRB = 2'd3;

  localparam int CTRL_BLANK_A = 7;
  localparam int CTRL_DP_A    = 6;
  localparam int CTRL_BLANK_B = 5;
  localparam int CTRL_DP_B    = 4;
  localparam int CTRL_BLANK_C = 3;
  localparam int CTRL_DP_C    = 2;
  localparam int CTRL_DP_D    = 0;

  localparam logic [13:0] BCD_MAX   = 14'd9999;
  localparam logic [3:0]  OVF_DIGIT = 4'hE;

  localparam int CONV_BITS = 14;
  localparam int WORD_W    = 30;

  // digits = {A,B,C,D}; blanking ripples from the left and stops at the first non-zero digit
  function automatic logic [7:0] build_ctrl(input logic [15:0] digits,
                                            input logic        blank_en,
                                            input logic        dp_en,
                                            input logic [1:0]  dp_pos);
    logic       blank_a;
    logic       blank_b;
    logic       blank_c;
    logic [7:0] ctrl;
    blank_a = blank_en && (digits[15:12] == 4'd0);
    blank_b = blank_a && (digits[11:8] == 4'd0);
    blank_c = blank_b && (digits[7:4] == 4'd0);
    ctrl = 8'h00;
    ctrl[CTRL_BLANK_A] = blank_a;
    ctrl[CTRL_BLANK_B] = blank_b;
    ctrl[CTRL_BLANK_C] = blank_c;
    ctrl[CTRL_DP_A]    = dp_en && (dp_pos == 2'd3);
    ctrl[CTRL_DP_B]    = dp_en && (dp_pos == 2'd2);
    ctrl[CTRL_DP_C]    = dp_en && (dp_pos == 2'd1);
    ctrl[CTRL_DP_D]    = dp_en && (dp_pos == 2'd0);
    return ctrl;
  endfunction

endpackage

// File: rtl/bin2bcd_seg_feeder_if.sv
// Request handshake, display write bus and status flags of the feeder.
// master = the feeder itself, slave = whatever drives requests and watches the bus.
interface bin2bcd_seg_feeder_if;
  logic [13:0] in_value;
  logic        in_dp_en;
  logic [1:0]  in_dp_pos;
  logic        in_lz_en;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data;
  logic        bus_wr;
  logic        bus_cen;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    input  in_value, in_dp_en, in_dp_pos, in_lz_en, in_valid,
    output in_ready, bus_addr, bus_data, bus_wr, bus_cen, busy, done, ovf
  );

  modport slave (
    output in_value, in_dp_en, in_dp_pos, in_lz_en, in_valid,
    input  in_ready, bus_addr, bus_data, bus_wr, bus_cen, busy, done, ovf
  );
endinterface

// File: rtl/bin2bcd_seg_feeder_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the
// whole {bcd[15:0], bin[13:0]} word left by one.
module bcd_dabble_step
  import bin2bcd_seg_feeder_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  assign o_word[0]           = 1'b0;
  assign o_word[CONV_BITS:1] = i_word[CONV_BITS-1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    localparam int LO = CONV_BITS + 4 * gi;
    logic [3:0] w_nib;
    assign w_nib = i_word[LO+3:LO];
    if (gi < 3) begin : g_full
      assign o_word[LO+4:LO+1] = (w_nib >= 4'd5) ? w_nib + 4'd3 : w_nib;
    end else begin : g_top
      // MSB of the top nibble shifts out of the word
      assign o_word[LO+3:LO+1] = (w_nib >= 4'd5) ? w_nib[2:0] + 3'd3 : w_nib[2:0];
    end
  end

endmodule

// File: rtl/bin2bcd_seg_feeder.sv
// Converts a 14-bit value to four BCD digits and writes Control, SegmentPairA
// and SegmentPairB into the seven-segment display over its 2-bit address bus.
module bin2bcd_seg_feeder
  import bin2bcd_seg_feeder_pkg::*;
#(
  parameter bit         WRITE_DIV = 1'b1,
  parameter logic [7:0] DIV_INIT  = 8'h01
)
(
  input  logic                  clk,
  input  logic                  rst,
  bin2bcd_seg_feeder_if.master  feed
);

  localparam state_t RESET_STATE = WRITE_DIV ? ST_INIT : ST_IDLE;

  state_t              r_state;
  state_t              w_state_next;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   w_shift_next;
  logic [WORD_W-1:0]   w_step;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_dp_en;
  logic [1:0]          r_dp_pos;
  logic                r_lz_en;
  logic                r_ovf;
  logic                r_in_ready;
  logic [1:0]          r_bus_addr;
  logic [7:0]          r_bus_data;
  logic                r_bus_wr;
  logic                r_done;
  logic                w_accept;
  logic [1:0]          w_bus_addr_next;
  logic [7:0]          w_bus_data_next;
  logic                w_bus_wr_next;
  logic [15:0]         w_final_digits;
  logic [7:0]          w_ctrl;

  bcd_dabble_step u_step (
    .i_word (r_shift),
    .o_word (w_step)
  );

  assign w_final_digits = r_ovf ? {4{OVF_DIGIT}} : w_step[WORD_W-1:CONV_BITS];
  assign w_ctrl         = build_ctrl(w_final_digits, r_lz_en && !r_ovf, r_dp_en, r_dp_pos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus registers are loaded from the state being left, so each write is
  // visible on the bus during the cycle its write state is active.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_cnt_next      = r_cnt;
    w_accept        = 1'b0;
    w_bus_wr_next   = 1'b0;
    w_bus_addr_next = r_bus_addr;
    w_bus_data_next = r_bus_data;
    case (r_state)
      ST_INIT: begin
        w_state_next    = ST_IDLE;
        w_bus_wr_next   = 1'b1;
        w_bus_addr_next = ADDR_DIV;
        w_bus_data_next = DIV_INIT;
      end
      ST_IDLE: begin
        if (r_in_ready && feed.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_CONV;
          w_shift_next = {16'h0000, feed.in_value};
          w_cnt_next   = 4'd0;
        end
      end
      ST_CONV: begin
        w_shift_next = w_step;
        w_cnt_next   = r_cnt + 4'd1;
        if (r_cnt == 4'(CONV_BITS - 1)) begin
          w_state_next    = ST_WR_CTRL;
          w_shift_next    = {w_final_digits, w_step[CONV_BITS-1:0]};
          w_bus_wr_next   = 1'b1;
          w_bus_addr_next = ADDR_CTRL;
          w_bus_data_next = w_ctrl;
        end
      end
      ST_WR_CTRL: begin
        w_state_next    = ST_WR_A;
        w_bus_wr_next   = 1'b1;
        w_bus_addr_next = ADDR_PAIRA;
        w_bus_data_next = r_shift[WORD_W-1:CONV_BITS+8];
      end
      ST_WR_A: begin
        w_state_next    = ST_WR_B;
        w_bus_wr_next   = 1'b1;
        w_bus_addr_next = ADDR_PAIRB;
        w_bus_data_next = r_shift[CONV_BITS+7:CONV_BITS];
      end
      ST_WR_B: w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_dp_en    <= 1'b0;
      r_dp_pos   <= '0;
      r_lz_en    <= 1'b0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b0;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_bus_wr   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_shift    <= w_shift_next;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_state_next == ST_IDLE);
      r_done     <= (w_state_next == ST_DONE);
      r_bus_addr <= w_bus_addr_next;
      r_bus_data <= w_bus_data_next;
      r_bus_wr   <= w_bus_wr_next;
      if (w_accept) begin
        r_dp_en  <= feed.in_dp_en;
        r_dp_pos <= feed.in_dp_pos;
        r_lz_en  <= feed.in_lz_en;
        r_ovf    <= (feed.in_value > BCD_MAX);
      end
    end
  end

  assign feed.in_ready = r_in_ready;
  assign feed.bus_addr = r_bus_addr;
  assign feed.bus_data = r_bus_data;
  assign feed.bus_wr   = r_bus_wr;
  assign feed.bus_cen  = r_bus_wr;
  assign feed.busy     = (r_state != ST_IDLE);
  assign feed.done     = r_done;
  assign feed.ovf      = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seg_feeder.sv
// Directed-vector bench for bin2bcd_seg_feeder: checks the divisor write after
// reset, exact write timing and contents per transfer, overflow and abort.
module tb_bin2bcd_seg_feeder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bin2bcd_seg_feeder_if u_if ();

  bin2bcd_seg_feeder #(
    .WRITE_DIV (1'b1),
    .DIV_INIT  (8'h20)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .feed (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in a cycle where the feeder should be ready; that cycle is N.
  task automatic run_xfer(input string tag, input logic [13:0] val, input logic dp_en,
                          input logic [1:0] dp_pos, input logic lz_en, input logic hold,
                          input logic [7:0] e_ctrl, input logic [7:0] e_a,
                          input logic [7:0] e_b, input logic e_ovf);
    logic [7:0] got_ctrl;
    logic [7:0] got_a;
    logic [7:0] got_b;
    chk($sformatf("%s.ready_at_N", tag), 32'(u_if.in_ready), 32'd1);
    u_if.in_value  = val;
    u_if.in_dp_en  = dp_en;
    u_if.in_dp_pos = dp_pos;
    u_if.in_lz_en  = lz_en;
    u_if.in_valid  = 1'b1;
    step();
    if (!hold) u_if.in_valid = 1'b0;
    // inputs must be ignored while busy
    u_if.in_value  = 14'h2A5A;
    u_if.in_lz_en  = ~lz_en;
    u_if.in_dp_en  = ~dp_en;
    chk($sformatf("%s.busy", tag), 32'(u_if.busy), 32'd1);
    chk($sformatf("%s.ready_busy", tag), 32'(u_if.in_ready), 32'd0);
    chk($sformatf("%s.ovf", tag), 32'(u_if.ovf), 32'(e_ovf));
    repeat (13) step();
    chk($sformatf("%s.wr_N14", tag), 32'(u_if.bus_wr), 32'd0);
    step();
    got_ctrl = u_if.bus_data;
    chk($sformatf("%s.wr_N15", tag), 32'(u_if.bus_wr), 32'd1);
    chk($sformatf("%s.cen_N15", tag), 32'(u_if.bus_cen), 32'd1);
    chk($sformatf("%s.addr_ctrl", tag), 32'(u_if.bus_addr), 32'd0);
    chk($sformatf("%s.ctrl", tag), 32'(u_if.bus_data), 32'(e_ctrl));
    step();
    got_a = u_if.bus_data;
    chk($sformatf("%s.wr_N16", tag), 32'(u_if.bus_wr), 32'd1);
    chk($sformatf("%s.addr_a", tag), 32'(u_if.bus_addr), 32'd2);
    chk($sformatf("%s.pair_a", tag), 32'(u_if.bus_data), 32'(e_a));
    step();
    got_b = u_if.bus_data;
    chk($sformatf("%s.wr_N17", tag), 32'(u_if.bus_wr), 32'd1);
    chk($sformatf("%s.addr_b", tag), 32'(u_if.bus_addr), 32'd3);
    chk($sformatf("%s.pair_b", tag), 32'(u_if.bus_data), 32'(e_b));
    chk($sformatf("%s.done_early", tag), 32'(u_if.done), 32'd0);
    step();
    chk($sformatf("%s.done_N18", tag), 32'(u_if.done), 32'd1);
    chk($sformatf("%s.wr_N18", tag), 32'(u_if.bus_wr), 32'd0);
    chk($sformatf("%s.cen_N18", tag), 32'(u_if.bus_cen), 32'd0);
    step();
    chk($sformatf("%s.done_N19", tag), 32'(u_if.done), 32'd0);
    chk($sformatf("%s.busy_N19", tag), 32'(u_if.busy), 32'd0);
    chk($sformatf("%s.ovf_hold", tag), 32'(u_if.ovf), 32'(e_ovf));
    $display("xfer %-8s value=%0d ctrl=%02h pairA=%02h pairB=%02h ovf=%0b", tag, val,
             got_ctrl, got_a, got_b, u_if.ovf);
  endtask

  task automatic reset_release_and_div();
    rst = 1'b0;
    step();
    chk("div.wr", 32'(u_if.bus_wr), 32'd1);
    chk("div.cen", 32'(u_if.bus_cen), 32'd1);
    chk("div.addr", 32'(u_if.bus_addr), 32'd1);
    chk("div.data", 32'(u_if.bus_data), 32'h20);
    step();
    chk("div.wr_off", 32'(u_if.bus_wr), 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    u_if.in_value  = '0;
    u_if.in_dp_en  = 1'b0;
    u_if.in_dp_pos = '0;
    u_if.in_lz_en  = 1'b0;
    u_if.in_valid  = 1'b0;
    repeat (3) step();
    chk("rst.addr", 32'(u_if.bus_addr), 32'd0);
    chk("rst.data", 32'(u_if.bus_data), 32'd0);
    chk("rst.wr", 32'(u_if.bus_wr), 32'd0);
    chk("rst.cen", 32'(u_if.bus_cen), 32'd0);
    chk("rst.done", 32'(u_if.done), 32'd0);
    chk("rst.ovf", 32'(u_if.ovf), 32'd0);
    chk("rst.ready", 32'(u_if.in_ready), 32'd0);
    reset_release_and_div();

    //        tag       value   dpe   pos   lz    hold  ctrl   A      B      ovf
    run_xfer("v1234",   14'd1234,  1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 8'h12, 8'h34, 1'b0);
    run_xfer("v42",     14'd42,    1'b0, 2'd0, 1'b1, 1'b0, 8'hA0, 8'h00, 8'h42, 1'b0);
    run_xfer("v0",      14'd0,     1'b0, 2'd0, 1'b1, 1'b0, 8'hA8, 8'h00, 8'h00, 1'b0);
    run_xfer("v10000",  14'd10000, 1'b1, 2'd1, 1'b1, 1'b0, 8'h04, 8'hEE, 8'hEE, 1'b1);
    run_xfer("v100",    14'd100,   1'b1, 2'd2, 1'b1, 1'b0, 8'h90, 8'h01, 8'h00, 1'b0);
    run_xfer("v16383",  14'd16383, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'hEE, 8'hEE, 1'b1);
    run_xfer("v9999",   14'd9999,  1'b1, 2'd3, 1'b0, 1'b1, 8'h40, 8'h99, 8'h99, 1'b0);
    // in_valid still high: this one is accepted in the very cycle ready returns
    run_xfer("v305",    14'd305,   1'b1, 2'd0, 1'b1, 1'b0, 8'h81, 8'h03, 8'h05, 1'b0);

    // abort in the middle of a conversion that had set ovf
    u_if.in_value  = 14'd12000;
    u_if.in_dp_en  = 1'b0;
    u_if.in_lz_en  = 1'b1;
    u_if.in_valid  = 1'b1;
    step();
    u_if.in_valid = 1'b0;
    chk("abort.ovf_set", 32'(u_if.ovf), 32'd1);
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk("abort.ovf_clr", 32'(u_if.ovf), 32'd0);
    chk("abort.ready", 32'(u_if.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort.wr%0d", i), 32'(u_if.bus_wr), 32'd0);
      chk($sformatf("abort.done%0d", i), 32'(u_if.done), 32'd0);
    end
    reset_release_and_div();
    run_xfer("v5",      14'd5,     1'b0, 2'd0, 1'b1, 1'b0, 8'hA8, 8'h00, 8'h05, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
